// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch-stage types and constants
package rv_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_JALR   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory request/response bundle
interface if_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; force > flush > stall > load > bubble
module if_id_reg
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_force,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_valid
);

  // Bubbles keep the previous PC fields; only the instruction and valid bit change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instr <= NOP_INSTR;
      o_pc    <= '0;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_force || (!i_flush && !i_stall && i_load)) begin
      o_instr <= i_instr;
      o_pc    <= i_pc;
      o_pc4   <= i_pc + XLEN'(4);
      o_valid <= 1'b1;
    end else if (i_flush || !i_stall) begin
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - fetch stage: next-PC select, one-outstanding imem fetch, IF/ID load
// Optional IF_MISALIGN_EXC_EN: adds misalignD and halts fetch on a redirect target with bit 1 set.
module if_fetch
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  if_fetch_if.master      imem,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
`ifdef IF_MISALIGN_EXC_EN
  output logic            misalignD,
`endif
  output logic            ValidD
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pcf, r_req_pc, r_hold_pc, w_target, w_ld_pc;
  logic [31:0]     r_hold_instr, w_ld_instr;
  logic            r_hold_v;
  logic            w_redirect, w_req, w_accept, w_resp, w_capture, w_drain;
  logic            w_halt, w_force;

  assign w_redirect = (PCSrc == PCSRC_TARGET) || (PCSrc == PCSRC_JALR);
  assign w_target   = (PCSrc == PCSRC_TARGET) ? PCTargetE
                                              : (ALUResultE & {{(XLEN-1){1'b1}}, 1'b0});
  assign w_accept   = w_req & imem.imem_gnt;
  // A response counts only for a live request with no redirect landing in the same cycle.
  assign w_resp     = (r_state == WAIT) & imem.imem_rvalid & ~w_redirect;
  assign w_capture  = w_resp & StallD & ~FlushD;
  assign w_drain    = r_hold_v & ~StallD & ~w_redirect;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pcf;

`ifdef IF_MISALIGN_EXC_EN
  logic r_halt, r_misalign;

  assign w_force   = w_redirect & w_target[1];
  assign w_halt    = r_halt;
  assign misalignD = r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_redirect) r_halt <= w_target[1];
      if (w_force) r_misalign <= 1'b1;
      else if (FlushD || !StallD) r_misalign <= 1'b0;
    end
  end
`else
  assign w_force = 1'b0;
  assign w_halt  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req = ~rst & ~StallF & ~r_hold_v & ~w_redirect & ~w_halt;
        if (w_req && imem.imem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) w_state_nxt = IDLE;
        else if (w_redirect) w_state_nxt = KILL;
      end
      KILL: begin
        if (imem.imem_rvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pcf        <= RESET_PC;
      r_req_pc     <= '0;
      r_hold_v     <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect) r_pcf <= w_target;
      else if (w_accept) r_pcf <= r_pcf + XLEN'(4);
      if (w_accept) r_req_pc <= r_pcf;
      if (w_redirect) r_hold_v <= 1'b0;
      else if (w_capture) r_hold_v <= 1'b1;
      else if (!StallD) r_hold_v <= 1'b0;
      if (w_capture) begin
        r_hold_instr <= imem.imem_rdata;
        r_hold_pc    <= r_req_pc;
      end
    end
  end

  assign w_ld_instr = w_force ? NOP_INSTR : (w_drain ? r_hold_instr : imem.imem_rdata);
  assign w_ld_pc    = w_force ? w_target : (w_drain ? r_hold_pc : r_req_pc);

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_force (w_force),
    .i_flush (FlushD),
    .i_stall (StallD),
    .i_load  (w_resp | w_drain),
    .i_instr (w_ld_instr),
    .i_pc    (w_ld_pc),
    .o_instr (InstrD),
    .o_pc    (PCD),
    .o_pc4   (PCPlus4D),
    .o_valid (ValidD)
  );

endmodule
